dcache_burst_collect: RTL and testbench
=======================================

Name: dcache_burst_collect

Overview:
- Upstream neighbour of the data-cache read-extract stage.
- On a read miss or uncached access, issues one Avalon-MM burst read of 1–3 dwords.
- Collects the returned 32-bit beats into a 96-bit read_data buffer and signals completion.
- Downstream logic uses read_data together with the original address and length to extract the requested bytes.

Parameters:
- None (data-path widths fixed: 32-bit bus, 96-bit buffer, max burst 3).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- start_address  in  30  dword address (byte address [31:2]) of first beat.
- start_dword_length  in  2  burst length in dwords, 1..3; value 0 treated as 1.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when all beats are collected.
- read_data  out  96  beat0 in [31:0], beat1 in [63:32], beat2 in [95:64]; unreceived words are 0.
- avm_address  out  32  {start_address, 2'b00} held during the command phase.
- avm_read  out  1  read command strobe.
- avm_burstcount  out  2  number of beats requested.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall; command is held while high.
- avm_readdatavalid  in  1  beat valid.
- avm_readdata  in  32  beat data.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, read_data=0, beat counter=0.
  - Reset has priority over every other event, including mid-burst.
  - Beats in flight at reset are not tracked; the memory side must be reset together.
- IDLE:
  - start=1 latches address and length (0→1).
  - Clears read_data to 0 and the beat counter to 0.
  - Next state: CMD; avm_read=1 from the next cycle.
  - avm_readdatavalid in IDLE is ignored.
- CMD:
  - avm_read=1; address and burstcount held stable.
  - Cycle with avm_waitrequest=0 → command accepted; avm_read drops the next cycle; next state DATA.
  - avm_readdatavalid is also honoured in CMD, on or after the acceptance cycle.
- DATA (beat handling, applies in CMD and DATA):
  - Each avm_readdatavalid=1 writes avm_readdata into word slot [counter] and increments the counter.
  - When the incremented counter equals the latched length → next state DONE.
  - A readdatavalid beyond the length is ignored.
- DONE:
  - done=1 for exactly one cycle; busy still 1; read_data holds all beats.
  - Next state IDLE with busy=0.
  - read_data holds its value until the next accepted start.
- start while busy=1 (including the done cycle) is ignored, not queued.
- Latency:
  - Zero wait states and beats back-to-back: start at cycle T; avm_read at T+1; beats at T+2..T+1+N; done at T+2+N.
- Burst contiguity: the burst stays within the request as issued; no splitting or alignment checks.

Test Plan:
- Single dword: start, addr=0x100 (byte 0x400), len=1, waitrequest=0, one beat 0xDEADBEEF.
  - avm_address=0x400, burstcount=1.
  - done 3 cycles after start; read_data=96'h0_0_DEADBEEF.
- Three dwords with stalls: len=3, waitrequest high for 4 cycles, beats 0x11111111, 0x22222222, 0x33333333 with a 2-cycle gap before the last.
  - avm_read held for 5 cycles with address stable.
  - read_data=96'h33333333_22222222_11111111; single done pulse.
- Length 0: start with len=0.
  - burstcount=1; completes as in the single-dword case.
- Busy start ignored: second start during DATA and on the done cycle.
  - No new avm_read; read_data unchanged; exactly one done.
- Reset mid-burst: len=2, rst after the first beat.
  - Next cycle: busy=0, avm_read=0, read_data=0.
  - A new start with len=2 returns the correct 2 beats.
- Early/stray beats: readdatavalid in IDLE, and a 4th beat on a len=3 burst.
  - Both ignored; read_data contains only the 3 expected beats.

Source files
------------

// File: rtl/dcache_burst_collect.sv
// Burst-read collector: issues one Avalon-MM read burst of 1-3 dwords and
// packs the returned beats into a 96-bit buffer for the read-extract stage.

module dcache_burst_slot #(
    parameter int VEC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [VEC_W-1:0] wdata,
    output logic [VEC_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (wr_en)
            q <= wdata;
    end

endmodule

module dcache_burst_collect (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [29:0] start_address,
    input  logic [1:0]  start_dword_length,
    output logic        busy,
    output logic        done,
    output logic [95:0] read_data,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [1:0]  avm_burstcount,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata
);

    localparam int NUM_LANES = 3;
    localparam int VEC_W     = 32;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [1:0]  len;
    } req_t;

    state_t state_q, state_d;
    req_t   req_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_nxt;
    logic       accept;
    logic       beat_fire;
    logic       last_beat;
    logic [NUM_LANES-1:0][VEC_W-1:0] slot_q;

    assign accept  = (state_q == IDLE) && start;
    assign cnt_nxt = cnt_q + 2'd1;

    // Beats count in CMD only on the acceptance cycle; a slave that stalls
    // the command cannot legally have returned data yet.
    assign beat_fire = avm_readdatavalid && (cnt_q < req_q.len) &&
                       ((state_q == DATA) || (state_q == CMD && !avm_waitrequest));
    assign last_beat = beat_fire && (cnt_nxt == req_q.len);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = CMD;
            CMD: begin
                if (last_beat)
                    state_d = DONE;
                else if (!avm_waitrequest)
                    state_d = DATA;
            end
            DATA: if (last_beat) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        avm_read = 1'b0;
        case (state_q)
            CMD: begin
                busy     = 1'b1;
                avm_read = 1'b1;
            end
            DATA: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // A length of 0 is promoted to a single-dword burst at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
            cnt_q <= 2'd0;
        end else if (accept) begin
            req_q.addr <= start_address;
            req_q.len  <= (start_dword_length == 2'd0) ? 2'd1 : start_dword_length;
            cnt_q      <= 2'd0;
        end else if (beat_fire) begin
            cnt_q <= cnt_nxt;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_slot
            dcache_burst_slot #(.VEC_W(VEC_W)) u_slot (
                .clk   (clk),
                .rst   (rst),
                .clr   (accept),
                .wr_en (beat_fire && (cnt_q == 2'(i))),
                .wdata (avm_readdata),
                .q     (slot_q[i])
            );
        end
    endgenerate

    assign read_data      = slot_q;
    assign avm_address    = {req_q.addr, 2'b00};
    assign avm_burstcount = req_q.len;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_dcache_burst_collect.sv
// Directed self-checking bench for dcache_burst_collect.

module tb_dcache_burst_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [29:0] start_address;
    logic [1:0]  start_dword_length;
    logic        busy;
    logic        done;
    logic [95:0] read_data;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [1:0]  avm_burstcount;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;

    int n_chk  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int rd0, dn0;

    dcache_burst_collect dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .start_address      (start_address),
        .start_dword_length (start_dword_length),
        .busy               (busy),
        .done               (done),
        .read_data          (read_data),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_burstcount     (avm_burstcount),
        .avm_byteenable     (avm_byteenable),
        .avm_waitrequest    (avm_waitrequest),
        .avm_readdatavalid  (avm_readdatavalid),
        .avm_readdata       (avm_readdata)
    );

    always #5 clk = ~clk;

    // Cycle-level monitors for command strobes and done pulses.
    always @(negedge clk) begin
        if (avm_read === 1'b1) rd_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [29:0] addr, input logic [1:0] len);
        start              = 1'b1;
        start_address      = addr;
        start_dword_length = len;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        tick();
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_address = '0;
        start_dword_length = '0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_bc", avm_burstcount, 0);
        check("rst_data", read_data, 0);
        check("rst_be", avm_byteenable, 4'hF);
        rst = 1'b0;
        tick();

        // Single dword
        rd0 = rd_cnt; dn0 = done_cnt;
        do_start(30'h100, 2'd1);
        check("t1_busy", busy, 1);
        check("t1_read", avm_read, 1);
        check("t1_addr", avm_address, 32'h400);
        check("t1_bc", avm_burstcount, 1);
        tick();
        check("t1_read_drop", avm_read, 0);
        beat(32'hDEADBEEF);
        check("t1_done", done, 1);
        check("t1_data", read_data, 96'h0_00000000_DEADBEEF);
        tick();
        check("t1_done_low", done, 0);
        check("t1_idle", busy, 0);
        check("t1_hold", read_data, 96'h0_00000000_DEADBEEF);
        check("t1_rdcnt", rd_cnt - rd0, 1);
        check("t1_dncnt", done_cnt - dn0, 1);

        // Three dwords with command stalls and a data gap
        rd0 = rd_cnt; dn0 = done_cnt;
        do_start(30'h2A0, 2'd3);
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_read_stall", avm_read, 1);
            check("t2_addr_stall", avm_address, 32'hA80);
            check("t2_bc", avm_burstcount, 3);
            tick();
        end
        avm_waitrequest = 1'b0;
        check("t2_read_acc", avm_read, 1);
        check("t2_data_clr", read_data, 0);
        tick();
        check("t2_read_drop", avm_read, 0);
        beat(32'h11111111);
        beat(32'h22222222);
        tick();
        tick();
        check("t2_not_done", done, 0);
        beat(32'h33333333);
        check("t2_done", done, 1);
        check("t2_data", read_data, 96'h33333333_22222222_11111111);
        tick();
        check("t2_rdcnt", rd_cnt - rd0, 5);
        check("t2_dncnt", done_cnt - dn0, 1);

        // Length 0 behaves as length 1
        rd0 = rd_cnt; dn0 = done_cnt;
        do_start(30'h3FFFFFFF, 2'd0);
        check("t3_bc", avm_burstcount, 1);
        check("t3_addr", avm_address, 32'hFFFFFFFC);
        tick();
        beat(32'h0BADF00D);
        check("t3_done", done, 1);
        check("t3_data", read_data, 96'h0_00000000_0BADF00D);
        tick();
        check("t3_dncnt", done_cnt - dn0, 1);

        // Start while busy is ignored (during DATA and on the done cycle)
        rd0 = rd_cnt; dn0 = done_cnt;
        do_start(30'h10, 2'd2);
        tick();
        start = 1'b1;
        start_address = 30'h77;
        start_dword_length = 2'd3;
        beat(32'hA1A1A1A1);
        beat(32'hA2A2A2A2);
        check("t4_done", done, 1);
        tick();
        start = 1'b0;
        check("t4_idle", busy, 0);
        check("t4_addr", avm_address, 32'h40);
        check("t4_data", read_data, 96'h0_A2A2A2A2_A1A1A1A1);
        tick();
        check("t4_still_idle", busy, 0);
        check("t4_rdcnt", rd_cnt - rd0, 1);
        check("t4_dncnt", done_cnt - dn0, 1);

        // Reset mid-burst, then a clean len=2 burst
        do_start(30'h55, 2'd2);
        tick();
        beat(32'hB1B1B1B1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_read", avm_read, 0);
        check("t5_data", read_data, 0);
        check("t5_addr", avm_address, 0);
        rd0 = rd_cnt; dn0 = done_cnt;
        do_start(30'h66, 2'd2);
        check("t5_addr2", avm_address, 32'h198);
        check("t5_bc2", avm_burstcount, 2);
        tick();
        beat(32'hC1C1C1C1);
        beat(32'hC2C2C2C2);
        check("t5_done", done, 1);
        check("t5_data2", read_data, 96'h0_C2C2C2C2_C1C1C1C1);
        tick();
        check("t5_dncnt", done_cnt - dn0, 1);

        // Stray beat in IDLE and a 4th beat on a len=3 burst
        beat(32'hFFFF0000);
        check("t6_idle_stray", read_data, 96'h0_C2C2C2C2_C1C1C1C1);
        dn0 = done_cnt;
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hEEEEEEEE;
        do_start(30'h20, 2'd3);
        avm_readdatavalid = 1'b0;
        check("t6_clr", read_data, 0);
        tick();
        beat(32'hD1D1D1D1);
        beat(32'hD2D2D2D2);
        beat(32'hD3D3D3D3);
        check("t6_done", done, 1);
        beat(32'hD4D4D4D4);
        check("t6_data", read_data, 96'hD3D3D3D3_D2D2D2D2_D1D1D1D1);
        check("t6_idle", busy, 0);
        tick();
        check("t6_dncnt", done_cnt - dn0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
